ex_div: RTL and testbench
=========================

# ex_div

Iterative radix-2 integer divider for the RV64M DIV/DIVU/REM/REMU and DIVW/DIVUW/REMW/REMUW instructions, living in the EX stage. It accepts one operation at a time through a valid/ready handshake, computes in a fixed number of cycles, and holds the result until EX takes it. Its 64-bit result feeds `ex_wordgen` directly; for word ops, `ex_wordgen` sign-extends bits [31:0].

## Interface
Parameters: none. Widths come from `DATA_BUS` (64 bits).

- `clk`  in  1  system clock
- `rst`  in  1  reset, asynchronous, active-high
- `div_valid`  in  1  request valid
- `div_ready`  out  1  divider can accept a request (IDLE)
- `div_op_signed`  in  1  1 = DIV/REM family, 0 = DIVU/REMU family
- `div_op_rem`  in  1  1 = return remainder, 0 = return quotient
- `inst_word`  in  1  word op (xxW); operands taken from [31:0]
- `div_src1`  in  64  dividend
- `div_src2`  in  64  divisor
- `div_flush`  in  1  pipeline kill; aborts any operation in flight
- `div_res_valid`  out  1  result available
- `div_res_ready`  in  1  consumer takes the result
- `div_res_data`  out  64  quotient or remainder
- `div_busy`  out  1  high in any state other than IDLE

## Operation
- States: IDLE, BUSY, FIX, DONE.
- **IDLE:**
  - `div_ready` = 1.
  - On `div_valid`, latch the op bits.
  - Extend operands: when `inst_word` = 1, use [31:0], sign-extended if `div_op_signed`, else zero-extended. Otherwise use the full 64 bits.
  - Record the dividend and divisor signs (signed ops only) and store the absolute values.
  - Clear the remainder and the count. Go to BUSY.
- **BUSY:**
  - Perform one restoring step per cycle: shift {rem, quo} left 1; if rem ≥ divisor, subtract and set quo[0].
  - A 6-bit count runs 0..63. After step 63, go to FIX.
- **FIX (signed ops only; unsigned ops pass through unchanged):**
  - Negate the quotient if the signs differ and the divisor ≠ 0.
  - Negate the remainder if the dividend is negative.
  - Go to DONE.
- **DONE:**
  - `div_res_valid` = 1 and `div_res_data` is stable.
  - On `div_res_ready`, go to IDLE.
- **Special results (RISC-V):**
  - Divide by zero: quotient = all ones, remainder = extended dividend.
  - Signed overflow (min / −1): quotient = min, remainder = 0.
  - The natural iteration plus the FIX rule above produce both cases.
- **Flush:** `div_flush` in any state forces IDLE on the next edge with no result. Flush wins over a simultaneous `div_valid` or `div_res_ready`.
- **Reset:**
  - State = IDLE; all datapath registers = 0.
  - Outputs: `div_ready` = 1, `div_busy` = 0, `div_res_valid` = 0, `div_res_data` = 0.
  - Reset mid-operation discards the operation.

## Timing
- Accept edge at cycle N: BUSY covers cycles N+1..N+64, FIX is N+65, and `div_res_valid` first goes high in cycle N+66.
- The result is held in DONE indefinitely while `div_res_ready` = 0.
- The DONE-to-IDLE edge and a new accept cannot coincide; `div_ready` is 0 in DONE. Back-to-back throughput is 1 op per 67 cycles minimum.
- `div_res_data` is registered and drives no combinational path from the inputs.

## Configuration
- **`DIV_SPECIAL_FAST_EN` defined:**
  - In IDLE, a divisor of 0 after extension, or signed overflow (min / −1 at the operating width), skips BUSY/FIX.
  - The RISC-V special result is loaded directly and the block goes to DONE.
  - `div_res_valid` is high in cycle N+1.
- **Undefined:** all operations take the full 66-cycle path, with identical results.

## Structure
- Shared defines (`defines.v`):
  - `DATA_BUS`, `ZERO_DWORD`
  - the 2-bit state encodings `DIV_IDLE`/`DIV_BUSY`/`DIV_FIX`/`DIV_DONE`
  - `DIV_CNT_BUS` (5:0)
- One sub-module, `ex_div_prep`: combinational word/sign extension, sign capture and absolute value, plus detection of the special cases.

## Test plan
- DIVU 100 / 7, `inst_word` = 0 → result 14 in cycle N+66; REMU of the same operands → 2.
- DIV −7 / 2 → 0xFFFF_FFFF_FFFF_FFFD; REM −7 / 2 → 0xFFFF_FFFF_FFFF_FFFF.
- DIV by 0 with `div_src1` = −5 → 0xFFFF_FFFF_FFFF_FFFF; REM → 0xFFFF_FFFF_FFFF_FFFB. With `DIV_SPECIAL_FAST_EN`, valid in cycle N+1.
- DIVW with `div_src1` = 0xDEAD_BEEF_8000_0000, `div_src2` = 0xFFFF_FFFF → low 32 bits = 0x8000_0000. DIVUW of 0x1_0000_0010 / 4 → 4.
- Assert `div_flush` at BUSY count 30 → IDLE next cycle, `div_res_valid` never rises. The next op returns a correct result.
- Hold `div_res_ready` = 0 for 10 cycles in DONE → data stable, `div_ready` = 0. Assert async `rst` mid-BUSY → IDLE immediately, all outputs at reset values.

Source files
------------

// File: rtl/ex_div_pkg.sv
// Shared widths, state encoding and helpers for the EX-stage iterative divider.
package ex_div_pkg;

  localparam int unsigned DataBus = 64;
  localparam int unsigned WordW   = 32;
  localparam int unsigned DivCntW = 6;

  localparam logic [DataBus-1:0] ZeroDword = '0;

  typedef enum logic [1:0] {
    DivIdle = 2'b00,
    DivBusy = 2'b01,
    DivFix  = 2'b10,
    DivDone = 2'b11
  } div_state_e;

  function automatic logic [DataBus-1:0] twos_neg(input logic [DataBus-1:0] v);
    return ZeroDword - v;
  endfunction

endpackage

// File: rtl/ex_div_if.sv
// Request/response bundle between the EX stage (master) and the divider (slave).
interface ex_div_if;
  import ex_div_pkg::*;

  logic               div_valid;
  logic               div_ready;
  logic               div_op_signed;
  logic               div_op_rem;
  logic               inst_word;
  logic [DataBus-1:0] div_src1;
  logic [DataBus-1:0] div_src2;
  logic               div_flush;
  logic               div_res_valid;
  logic               div_res_ready;
  logic [DataBus-1:0] div_res_data;
  logic               div_busy;

  modport master (
    output div_valid, div_op_signed, div_op_rem, inst_word, div_src1, div_src2,
    output div_flush, div_res_ready,
    input  div_ready, div_res_valid, div_res_data, div_busy
  );

  modport slave (
    input  div_valid, div_op_signed, div_op_rem, inst_word, div_src1, div_src2,
    input  div_flush, div_res_ready,
    output div_ready, div_res_valid, div_res_data, div_busy
  );

endinterface

// File: rtl/ex_div_prep.sv
// Operand preparation: word/sign extension, sign capture, magnitudes and
// detection of divide-by-zero and signed overflow at the operating width.
module ex_div_prep
  import ex_div_pkg::*;
(
  input  logic               i_op_signed,
  input  logic               i_word,
  input  logic [DataBus-1:0] i_src1,
  input  logic [DataBus-1:0] i_src2,
  output logic [DataBus-1:0] o_ext_a,
  output logic [DataBus-1:0] o_abs_a,
  output logic [DataBus-1:0] o_abs_b,
  output logic               o_neg_a,
  output logic               o_neg_b,
  output logic               o_div_zero,
  output logic               o_ovf
);

  logic [DataBus-1:0] w_ext_b;
  logic [DataBus-1:0] w_min;

  always_comb begin
    if (i_word) begin
      o_ext_a = {{(DataBus-WordW){i_op_signed & i_src1[WordW-1]}}, i_src1[WordW-1:0]};
      w_ext_b = {{(DataBus-WordW){i_op_signed & i_src2[WordW-1]}}, i_src2[WordW-1:0]};
      // Most negative word value, already sign-extended to the full bus.
      w_min   = {{(DataBus-WordW+1){1'b1}}, {(WordW-1){1'b0}}};
    end else begin
      o_ext_a = i_src1;
      w_ext_b = i_src2;
      w_min   = {1'b1, {(DataBus-1){1'b0}}};
    end
    o_neg_a    = i_op_signed & o_ext_a[DataBus-1];
    o_neg_b    = i_op_signed & w_ext_b[DataBus-1];
    o_abs_a    = o_neg_a ? twos_neg(o_ext_a) : o_ext_a;
    o_abs_b    = o_neg_b ? twos_neg(w_ext_b) : w_ext_b;
    o_div_zero = (w_ext_b == ZeroDword);
    o_ovf      = i_op_signed && (o_ext_a == w_min) && (w_ext_b == {DataBus{1'b1}});
  end

endmodule

// File: rtl/ex_div.sv
// Iterative radix-2 restoring divider for RV64M DIV/REM (and W variants).
// Optional DIV_SPECIAL_FAST_EN short-circuits divide-by-zero and signed overflow.
module ex_div
  import ex_div_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  ex_div_if.slave div_if
);

  div_state_e           r_state;
  logic                 r_ready;
  logic                 r_busy;
  logic                 r_res_valid;
  logic                 r_op_rem;
  logic                 r_neg_a;
  logic                 r_neg_b;
  logic [DivCntW-1:0]   r_cnt;
  logic [DataBus-1:0]   r_rem;
  logic [DataBus-1:0]   r_quo;
  logic [DataBus-1:0]   r_divisor;
  logic [DataBus-1:0]   r_res;

  logic [DataBus-1:0]   w_ext_a;
  logic [DataBus-1:0]   w_abs_a;
  logic [DataBus-1:0]   w_abs_b;
  logic                 w_neg_a;
  logic                 w_neg_b;
  logic                 w_div_zero;
  logic                 w_ovf;
  logic                 w_fast;
  logic [DataBus-1:0]   w_special_res;
  logic [DataBus:0]     w_rem_sh;
  logic [DataBus:0]     w_diff;
  logic                 w_ge;
  logic [DataBus-1:0]   w_rem_nxt;
  logic [DataBus-1:0]   w_quo_nxt;
  logic [DataBus-1:0]   w_quo_fix;
  logic [DataBus-1:0]   w_rem_fix;

  ex_div_prep u_prep (
    .i_op_signed (div_if.div_op_signed),
    .i_word      (div_if.inst_word),
    .i_src1      (div_if.div_src1),
    .i_src2      (div_if.div_src2),
    .o_ext_a     (w_ext_a),
    .o_abs_a     (w_abs_a),
    .o_abs_b     (w_abs_b),
    .o_neg_a     (w_neg_a),
    .o_neg_b     (w_neg_b),
    .o_div_zero  (w_div_zero),
    .o_ovf       (w_ovf)
  );

  always_comb begin
    if (w_div_zero) begin
      w_special_res = div_if.div_op_rem ? w_ext_a : {DataBus{1'b1}};
    end else begin
      w_special_res = div_if.div_op_rem ? ZeroDword : w_ext_a;
    end
  end

`ifdef DIV_SPECIAL_FAST_EN
  assign w_fast = w_div_zero | w_ovf;
`else
  logic w_unused_special;
  assign w_fast           = 1'b0;
  assign w_unused_special = ^{w_div_zero, w_ovf, w_special_res};
`endif

  // One restoring step; the shifted remainder needs a 65th bit because the
  // divisor magnitude may use all 64 bits.
  always_comb begin
    w_rem_sh  = {r_rem, r_quo[DataBus-1]};
    w_diff    = w_rem_sh - {1'b0, r_divisor};
    w_ge      = (w_rem_sh >= {1'b0, r_divisor});
    w_rem_nxt = w_ge ? w_diff[DataBus-1:0] : w_rem_sh[DataBus-1:0];
    w_quo_nxt = {r_quo[DataBus-2:0], w_ge};
    w_quo_fix = ((r_neg_a ^ r_neg_b) && (r_divisor != ZeroDword)) ? twos_neg(r_quo) : r_quo;
    w_rem_fix = r_neg_a ? twos_neg(r_rem) : r_rem;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= DivIdle;
      r_ready     <= 1'b1;
      r_busy      <= 1'b0;
      r_res_valid <= 1'b0;
      r_op_rem    <= 1'b0;
      r_neg_a     <= 1'b0;
      r_neg_b     <= 1'b0;
      r_cnt       <= '0;
      r_rem       <= ZeroDword;
      r_quo       <= ZeroDword;
      r_divisor   <= ZeroDword;
      r_res       <= ZeroDword;
    end else if (div_if.div_flush) begin
      r_state     <= DivIdle;
      r_ready     <= 1'b1;
      r_busy      <= 1'b0;
      r_res_valid <= 1'b0;
    end else begin
      unique case (r_state)
        DivIdle: begin
          if (div_if.div_valid) begin
            r_op_rem  <= div_if.div_op_rem;
            r_neg_a   <= w_neg_a;
            r_neg_b   <= w_neg_b;
            r_quo     <= w_abs_a;
            r_divisor <= w_abs_b;
            r_rem     <= ZeroDword;
            r_cnt     <= '0;
            r_ready   <= 1'b0;
            r_busy    <= 1'b1;
            if (w_fast) begin
              r_res       <= w_special_res;
              r_res_valid <= 1'b1;
              r_state     <= DivDone;
            end else begin
              r_state <= DivBusy;
            end
          end
        end
        DivBusy: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt + DivCntW'(1);
          if (r_cnt == {DivCntW{1'b1}}) begin
            r_state <= DivFix;
          end
        end
        DivFix: begin
          r_res       <= r_op_rem ? w_rem_fix : w_quo_fix;
          r_res_valid <= 1'b1;
          r_state     <= DivDone;
        end
        DivDone: begin
          if (div_if.div_res_ready) begin
            r_res_valid <= 1'b0;
            r_ready     <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= DivIdle;
          end
        end
        default: r_state <= DivIdle;
      endcase
    end
  end

  assign div_if.div_ready     = r_ready;
  assign div_if.div_busy      = r_busy;
  assign div_if.div_res_valid = r_res_valid;
  assign div_if.div_res_data  = r_res;

endmodule

// File: tb/tb_ex_div.sv
// Directed self-checking bench for ex_div: latency, signed/unsigned/word ops,
// RISC-V special cases, flush, result hold and asynchronous reset.
module tb_ex_div;

`ifdef DIV_SPECIAL_FAST_EN
  localparam int FastLat = 1;
`else
  localparam int FastLat = 66;
`endif
  localparam int FullLat = 66;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  ex_div_if dif ();

  ex_div dut (
    .clk    (clk),
    .rst    (rst),
    .div_if (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request and wait (bounded) for the result; lat is the cycle
  // index relative to the accept edge at which res_valid was first seen.
  task automatic run_op(input logic sgn, input logic rem, input logic word,
                        input logic [63:0] a, input logic [63:0] b,
                        output logic [63:0] res, output int lat);
    @(negedge clk);
    dif.div_valid     = 1'b1;
    dif.div_op_signed = sgn;
    dif.div_op_rem    = rem;
    dif.inst_word     = word;
    dif.div_src1      = a;
    dif.div_src2      = b;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    dif.div_valid = 1'b0;
    while (dif.div_res_valid !== 1'b1 && lat < 200) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    res = dif.div_res_data;
  endtask

  task automatic take_result();
    @(negedge clk);
    dif.div_res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dif.div_res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if (dif.div_ready !== 1'b1 || dif.div_busy !== 1'b0 || dif.div_res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: ready=%b busy=%b valid=%b required 1 0 0",
               dif.div_ready, dif.div_busy, dif.div_res_valid);
    end
    n_tests++;
    if (dif.div_res_data !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_data: got %h required 0", dif.div_res_data);
    end
    rst = 1'b0;
  endtask

  task automatic test_unsigned();
    logic [63:0] res;
    int lat;
    run_op(1'b0, 1'b0, 1'b0, 64'd100, 64'd7, res, lat);
    n_tests++;
    if (lat != FullLat) begin
      n_fail++;
      $display("FAIL divu_latency: got %0d required %0d", lat, FullLat);
    end
    n_tests++;
    if (res !== 64'd14) begin
      n_fail++;
      $display("FAIL divu_100_7: got %h required %h", res, 64'd14);
    end
    n_tests++;
    if (dif.div_ready !== 1'b0 || dif.div_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL done_flags: ready=%b busy=%b required 0 1", dif.div_ready, dif.div_busy);
    end
    take_result();
    n_tests++;
    if (dif.div_ready !== 1'b1 || dif.div_res_valid !== 1'b0 || dif.div_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL after_take: ready=%b valid=%b busy=%b required 1 0 0",
               dif.div_ready, dif.div_res_valid, dif.div_busy);
    end
    run_op(1'b0, 1'b1, 1'b0, 64'd100, 64'd7, res, lat);
    n_tests++;
    if (res !== 64'd2) begin
      n_fail++;
      $display("FAIL remu_100_7: got %h required %h", res, 64'd2);
    end
    take_result();
  endtask

  task automatic test_signed();
    logic [63:0] res;
    int lat;
    run_op(1'b1, 1'b0, 1'b0, -64'sd7, 64'd2, res, lat);
    n_tests++;
    if (res !== 64'hFFFF_FFFF_FFFF_FFFD || lat != FullLat) begin
      n_fail++;
      $display("FAIL div_m7_2: got %h lat %0d required fffffffffffffffd lat %0d",
               res, lat, FullLat);
    end
    take_result();
    run_op(1'b1, 1'b1, 1'b0, -64'sd7, 64'd2, res, lat);
    n_tests++;
    if (res !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      n_fail++;
      $display("FAIL rem_m7_2: got %h required ffffffffffffffff", res);
    end
    take_result();
  endtask

  task automatic test_special();
    logic [63:0] res;
    int lat;
    run_op(1'b1, 1'b0, 1'b0, -64'sd5, 64'd0, res, lat);
    n_tests++;
    if (res !== 64'hFFFF_FFFF_FFFF_FFFF || lat != FastLat) begin
      n_fail++;
      $display("FAIL div_by_zero: got %h lat %0d required ffffffffffffffff lat %0d",
               res, lat, FastLat);
    end
    take_result();
    run_op(1'b1, 1'b1, 1'b0, -64'sd5, 64'd0, res, lat);
    n_tests++;
    if (res !== 64'hFFFF_FFFF_FFFF_FFFB || lat != FastLat) begin
      n_fail++;
      $display("FAIL rem_by_zero: got %h lat %0d required fffffffffffffffb lat %0d",
               res, lat, FastLat);
    end
    take_result();
    run_op(1'b0, 1'b0, 1'b0, 64'd12345, 64'd0, res, lat);
    n_tests++;
    if (res !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      n_fail++;
      $display("FAIL divu_by_zero: got %h required ffffffffffffffff", res);
    end
    take_result();
    run_op(1'b1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, res, lat);
    n_tests++;
    if (res !== 64'h8000_0000_0000_0000 || lat != FastLat) begin
      n_fail++;
      $display("FAIL div_overflow: got %h lat %0d required 8000000000000000 lat %0d",
               res, lat, FastLat);
    end
    take_result();
    run_op(1'b1, 1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, res, lat);
    n_tests++;
    if (res !== 64'd0) begin
      n_fail++;
      $display("FAIL rem_overflow: got %h required 0", res);
    end
    take_result();
  endtask

  task automatic test_word();
    logic [63:0] res;
    int lat;
    run_op(1'b1, 1'b0, 1'b1, 64'hDEAD_BEEF_8000_0000, 64'h0000_0000_FFFF_FFFF, res, lat);
    n_tests++;
    if (res[31:0] !== 32'h8000_0000 || lat != FastLat) begin
      n_fail++;
      $display("FAIL divw_overflow: got %h lat %0d required low 80000000 lat %0d",
               res, lat, FastLat);
    end
    take_result();
    run_op(1'b0, 1'b0, 1'b1, 64'h0000_0001_0000_0010, 64'd4, res, lat);
    n_tests++;
    if (res !== 64'd4 || lat != FullLat) begin
      n_fail++;
      $display("FAIL divuw: got %h lat %0d required 4 lat %0d", res, lat, FullLat);
    end
    take_result();
    run_op(1'b1, 1'b1, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'h0000_0000_0000_0003, res, lat);
    n_tests++;
    if (res[31:0] !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL remw_m7_3: got %h required low ffffffff", res);
    end
    take_result();
  endtask

  task automatic test_flush();
    logic [63:0] res;
    int lat;
    int seen;
    @(negedge clk);
    dif.div_valid     = 1'b1;
    dif.div_op_signed = 1'b0;
    dif.div_op_rem    = 1'b0;
    dif.inst_word     = 1'b0;
    dif.div_src1      = 64'd500;
    dif.div_src2      = 64'd3;
    @(posedge clk);
    @(negedge clk);
    dif.div_valid = 1'b0;
    // Count is 0 in the first BUSY cycle; advance to count 30.
    repeat (30) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (dif.div_busy !== 1'b1 || dif.div_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_mid_op: busy=%b ready=%b required 1 0", dif.div_busy, dif.div_ready);
    end
    dif.div_flush = 1'b1;
    @(posedge clk);
    #1;
    n_tests++;
    if (dif.div_ready !== 1'b1 || dif.div_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_idle: ready=%b busy=%b required 1 0", dif.div_ready, dif.div_busy);
    end
    @(negedge clk);
    dif.div_flush = 1'b0;
    seen = 0;
    repeat (80) begin
      @(negedge clk);
      if (dif.div_res_valid === 1'b1) seen = 1;
    end
    n_tests++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL flush_no_result: res_valid rose=%0d required 0", seen);
    end
    run_op(1'b0, 1'b0, 1'b0, 64'd1000, 64'd10, res, lat);
    n_tests++;
    if (res !== 64'd100 || lat != FullLat) begin
      n_fail++;
      $display("FAIL after_flush: got %h lat %0d required 64 lat %0d", res, lat, FullLat);
    end
    take_result();
  endtask

  task automatic test_hold();
    logic [63:0] res;
    int lat;
    run_op(1'b1, 1'b0, 1'b0, 64'd91, -64'sd7, res, lat);
    repeat (10) begin
      @(negedge clk);
      n_tests++;
      if (dif.div_res_data !== 64'hFFFF_FFFF_FFFF_FFF3 || dif.div_ready !== 1'b0 ||
          dif.div_res_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL hold: data=%h ready=%b valid=%b required fffffffffffffff3 0 1",
                 dif.div_res_data, dif.div_ready, dif.div_res_valid);
      end
    end
    take_result();
  endtask

  task automatic test_reset_mid();
    logic [63:0] res;
    int lat;
    @(negedge clk);
    dif.div_valid     = 1'b1;
    dif.div_op_signed = 1'b0;
    dif.div_op_rem    = 1'b0;
    dif.inst_word     = 1'b0;
    dif.div_src1      = 64'd77;
    dif.div_src2      = 64'd5;
    @(posedge clk);
    @(negedge clk);
    dif.div_valid = 1'b0;
    repeat (20) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (dif.div_ready !== 1'b1 || dif.div_busy !== 1'b0 || dif.div_res_valid !== 1'b0 ||
        dif.div_res_data !== 64'd0) begin
      n_fail++;
      $display("FAIL async_reset: ready=%b busy=%b valid=%b data=%h required 1 0 0 0",
               dif.div_ready, dif.div_busy, dif.div_res_valid, dif.div_res_data);
    end
    @(negedge clk);
    rst = 1'b0;
    run_op(1'b0, 1'b1, 1'b0, 64'd77, 64'd5, res, lat);
    n_tests++;
    if (res !== 64'd2 || lat != FullLat) begin
      n_fail++;
      $display("FAIL after_reset: got %h lat %0d required 2 lat %0d", res, lat, FullLat);
    end
    take_result();
  endtask

  task automatic test_back_to_back();
    logic [63:0] res;
    int lat;
    run_op(1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd16, res, lat);
    n_tests++;
    if (res !== 64'h0FFF_FFFF_FFFF_FFFF) begin
      n_fail++;
      $display("FAIL divu_max_16: got %h required 0fffffffffffffff", res);
    end
    take_result();
    run_op(1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd16, res, lat);
    n_tests++;
    if (res !== 64'd15 || lat != FullLat) begin
      n_fail++;
      $display("FAIL remu_max_16: got %h lat %0d required f lat %0d", res, lat, FullLat);
    end
    take_result();
  endtask

  initial begin
    n_tests           = 0;
    n_fail            = 0;
    rst               = 1'b1;
    dif.div_valid     = 1'b0;
    dif.div_op_signed = 1'b0;
    dif.div_op_rem    = 1'b0;
    dif.inst_word     = 1'b0;
    dif.div_src1      = 64'd0;
    dif.div_src2      = 64'd0;
    dif.div_flush     = 1'b0;
    dif.div_res_ready = 1'b0;
    test_reset();
    test_unsigned();
    test_signed();
    test_special();
    test_word();
    test_flush();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
